// File: rtl/echo_requester.sv
// Echo say/heard initiator: issues a seeded burst of say requests, checks each
// heard indication in order against a FIFO of expected values, with a watchdog.
module echo_requester #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start__ENA,
    input  logic [COUNT_W-1:0] start_count,
    input  logic [31:0]        start_seed,
    output logic               start__RDY,
    output logic               say__ENA,
    output logic [31:0]        say_meth,
    output logic [31:0]        say_v,
    input  logic               say__RDY,
    input  logic               heard__ENA,
    input  logic [31:0]        heard_meth,
    input  logic [31:0]        heard_v,
    output logic               heard__RDY,
    output logic               done,
    output logic [COUNT_W-1:0] err_count,
    output logic               timeout
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [COUNT_W-1:0] r_n;
    logic [COUNT_W-1:0] r_idx;
    logic [COUNT_W-1:0] r_err;
    logic [31:0]        r_seed;
    logic [63:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_rp;
    logic [AW:0]        r_occ;
    logic               r_timeout;
    logic [31:0]        r_wdog;

    logic w_full;
    logic w_empty;
    logic w_active;
    logic w_start;
    logic w_push;
    logic w_pop;
    logic w_mismatch;
    logic w_expire;

    assign w_full     = (r_occ == (AW+1)'(DEPTH));
    assign w_empty    = (r_occ == '0);
    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_start    = start__ENA && (r_state == S_IDLE);
    assign w_push     = say__ENA && say__RDY;
    assign w_pop      = heard__ENA && heard__RDY;
    assign w_mismatch = (r_mem[r_rp] != {heard_meth, heard_v});
    assign w_expire   = w_active && !w_empty && !w_pop
                        && (r_wdog == 32'(TIMEOUT - 1));

    assign start__RDY = (r_state == S_IDLE);
    assign say__ENA   = (r_state == S_RUN) && (r_idx < r_n) && !w_full;
    assign say_meth   = 32'(r_idx);
    assign say_v      = r_seed + 32'(r_idx);
    assign heard__RDY = !w_empty && w_active;
    assign done       = (r_state == S_DONE);
    assign err_count  = r_err;
    assign timeout    = r_timeout;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start__ENA) w_next = S_RUN;
            S_RUN: begin
                if (w_expire)           w_next = S_DONE;
                else if (r_idx == r_n)  w_next = S_DRAIN;
            end
            S_DRAIN: if (w_expire || w_empty) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_seed    <= '0;
            r_idx     <= '0;
            r_err     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_n       <= start_count;
                r_seed    <= start_seed;
                r_idx     <= '0;
                r_err     <= '0;
                r_timeout <= 1'b0;
            end else begin
                if (w_push) r_idx <= r_idx + 1'b1;
                if (w_pop && w_mismatch && (r_err != '1))
                    r_err <= r_err + 1'b1;
                if (w_expire) r_timeout <= 1'b1;
            end
        end
    end

    // Expiry flushes the FIFO and wins over any same-cycle push or pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_occ  <= '0;
            r_wdog <= '0;
        end else begin
            if (w_expire) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_occ <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop)  r_rp <= r_rp + 1'b1;
                if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
                else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
            end
            if (!w_active || w_empty || w_pop || w_expire)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wp] <= {say_meth, say_v};
    end

endmodule

// File: tb/tb_echo_requester.sv
// Scoreboard bench for echo_requester with a behavioural echo responder.
module tb_echo_requester;

    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int TO    = 1024;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start__ENA;
    logic [CW-1:0] start_count;
    logic [31:0]   start_seed;
    logic          start__RDY;
    logic          say__ENA;
    logic [31:0]   say_meth;
    logic [31:0]   say_v;
    logic          say__RDY;
    logic          heard__ENA;
    logic [31:0]   heard_meth;
    logic [31:0]   heard_v;
    logic          heard__RDY;
    logic          done;
    logic [CW-1:0] err_count;
    logic          timeout;

    echo_requester #(.DEPTH(DEPTH), .COUNT_W(CW), .TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start__ENA (start__ENA),
        .start_count(start_count),
        .start_seed (start_seed),
        .start__RDY (start__RDY),
        .say__ENA   (say__ENA),
        .say_meth   (say_meth),
        .say_v      (say_v),
        .say__RDY   (say__RDY),
        .heard__ENA (heard__ENA),
        .heard_meth (heard_meth),
        .heard_v    (heard_v),
        .heard__RDY (heard__RDY),
        .done       (done),
        .err_count  (err_count),
        .timeout    (timeout)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    typedef struct {
        logic [31:0] m;
        logic [31:0] v;
        int          rdy;
    } rsp_t;

    typedef struct {
        logic [CW-1:0] err;
        logic          to;
    } done_t;

    logic [63:0] exp_say[$];
    done_t       exp_done[$];
    rsp_t        rq[$];

    int checks = 0;
    int errors = 0;

    int delay   = 2;
    bit hold    = 0;
    bit silent  = 0;
    int corrupt = 0;

    int say_cnt   = 0;
    int heard_cnt = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int say_cyc   = 0;
    int start_cyc = 0;
    int outstanding = 0;
    int max_out     = 0;
    int done_target = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Responder: drives heard for the coming edge from its in-flight queue.
    initial begin
        rsp_t r;
        say__RDY   = 1'b1;
        heard__ENA = 1'b0;
        heard_meth = '0;
        heard_v    = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                rq.delete();
                heard__ENA = 1'b0;
            end else begin
                if (say__ENA && say__RDY) begin
                    r.m = say_meth;
                    r.v = say_v;
                    r.rdy = cyc + 1 + delay;
                    rq.push_back(r);
                end
                heard__ENA = 1'b0;
                if (!hold && !silent && rq.size() > 0 && rq[0].rdy <= cyc) begin
                    heard__ENA = 1'b1;
                    heard_meth = rq[0].m;
                    heard_v    = rq[0].v + ((corrupt > 0) ? 32'd1 : 32'd0);
                    if (heard__RDY) begin
                        void'(rq.pop_front());
                        if (corrupt > 0) corrupt--;
                    end
                end
            end
        end
    end

    // Monitor: pops expected say and done records as the DUT presents them.
    initial begin
        logic [63:0] e;
        done_t d;
        forever begin
            @(negedge CLK);
            #1;
            if (!RST) begin
                if (say__ENA && say__RDY) begin
                    say_cnt++;
                    say_cyc = cyc + 1;
                    outstanding++;
                    if (exp_say.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL say_unexpected: got %0h/%0h, required none",
                                 say_meth, say_v);
                    end else begin
                        e = exp_say.pop_front();
                        chk("say_fields", {say_meth, say_v}, e);
                    end
                end
                if (heard__ENA && heard__RDY) begin
                    heard_cnt++;
                    outstanding--;
                end
                if (outstanding > max_out) max_out = outstanding;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got done=1, required 0");
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_err_count", 64'(err_count), 64'(d.err));
                        chk("done_timeout", 64'(timeout), 64'(d.to));
                    end
                end
            end
        end
    end

    task automatic do_start(input int n, input logic [31:0] seed,
                            input bit want_done, input logic [CW-1:0] e_err,
                            input bit e_to);
        done_t d;
        for (int i = 0; i < n; i++)
            exp_say.push_back({32'(i), seed + 32'(i)});
        if (want_done) begin
            d.err = e_err;
            d.to  = e_to;
            exp_done.push_back(d);
            done_target++;
        end
        @(negedge CLK);
        #2;
        start__ENA  = 1'b1;
        start_count = CW'(n);
        start_seed  = seed;
        start_cyc   = cyc + 1;
        @(negedge CLK);
        #2;
        start__ENA = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bool_loop: begin
            for (int k = 0; k < budget; k++) begin
                @(negedge CLK);
                #2;
                if (done_cnt >= done_target) disable bool_loop;
            end
            checks++;
            errors++;
            $display("FAIL %s_wait: got done_cnt=%0d, required %0d",
                     name, done_cnt, done_target);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_rdy"}, 64'(start__RDY), 64'd1);
        chk({tag, "_say_ena"},   64'(say__ENA),   64'd0);
        chk({tag, "_say_meth"},  64'(say_meth),   64'd0);
        chk({tag, "_say_v"},     64'(say_v),      64'd0);
        chk({tag, "_heard_rdy"}, 64'(heard__RDY), 64'd0);
        chk({tag, "_done"},      64'(done),       64'd0);
        chk({tag, "_err_count"}, 64'(err_count),  64'd0);
        chk({tag, "_timeout"},   64'(timeout),    64'd0);
    endtask

    initial begin
        int s0;
        int h0;
        RST         = 1'b1;
        start__ENA  = 1'b0;
        start_count = '0;
        start_seed  = '0;
        repeat (3) @(negedge CLK);
        #2;
        chk_reset_outputs("reset");
        RST = 1'b0;

        // Burst of 3, echo after 2 cycles.
        delay = 2;
        s0 = say_cnt;
        do_start(3, 32'h100, 1'b1, '0, 1'b0);
        wait_done("t1", 60);
        chk("t1_say_count", 64'(say_cnt - s0), 64'd3);
        @(negedge CLK);
        #2;
        chk("t1_start_rdy_after", 64'(start__RDY), 64'd1);

        // Responder holds heard off: FIFO fills to DEPTH then say stalls.
        hold    = 1'b1;
        delay   = 0;
        max_out = 0;
        s0 = say_cnt;
        do_start(8, 32'h200, 1'b1, '0, 1'b0);
        repeat (20) @(negedge CLK);
        #2;
        chk("t2_say_stall_count", 64'(say_cnt - s0), 64'd4);
        chk("t2_say_ena_low", 64'(say__ENA), 64'd0);
        chk("t2_heard_rdy", 64'(heard__RDY), 64'd1);
        hold = 1'b0;
        wait_done("t2", 100);
        chk("t2_say_total", 64'(say_cnt - s0), 64'd8);
        chk("t2_max_outstanding", 64'(max_out), 64'(DEPTH));

        // First echo returns a wrong v.
        delay   = 1;
        corrupt = 1;
        do_start(2, 32'h100, 1'b1, CW'(1), 1'b0);
        wait_done("t3", 60);

        // No answer: watchdog expires TIMEOUT cycles after the say.
        silent = 1'b1;
        do_start(1, 32'h300, 1'b1, '0, 1'b1);
        wait_done("t4", TO + 100);
        chk("t4_timeout_latency", 64'(done_cyc - say_cyc), 64'(TO));
        @(negedge CLK);
        #2;
        chk("t4_start_rdy_after", 64'(start__RDY), 64'd1);
        chk("t4_fifo_empty", 64'(heard__RDY), 64'd0);
        chk("t4_timeout_sticky", 64'(timeout), 64'd1);
        silent = 1'b0;
        rq.delete();
        outstanding = 0;

        // Reset while the third heard is presented.
        delay = 2;
        h0 = heard_cnt;
        do_start(5, 32'h400, 1'b0, '0, 1'b0);
        #1;
        chk("t5_timeout_cleared", 64'(timeout), 64'd0);
        begin : t5_wait
            for (int k = 0; k < 100; k++) begin
                if (heard_cnt - h0 >= 2 && heard__ENA) disable t5_wait;
                @(negedge CLK);
                #2;
            end
            checks++;
            errors++;
            $display("FAIL t5_wait: got heard=%0d, required 2", heard_cnt - h0);
        end
        RST = 1'b1;
        #1;
        chk_reset_outputs("t5_reset");
        exp_say.delete();
        outstanding = 0;
        repeat (2) @(negedge CLK);
        #2;
        RST = 1'b0;
        do_start(1, 32'h500, 1'b1, '0, 1'b0);
        wait_done("t5_restart", 60);

        // Empty burst.
        s0 = say_cnt;
        do_start(0, 32'h600, 1'b1, '0, 1'b0);
        wait_done("t6", 20);
        chk("t6_done_latency", 64'(done_cyc - start_cyc), 64'd2);
        chk("t6_no_say", 64'(say_cnt - s0), 64'd0);

        repeat (3) @(negedge CLK);
        chk("exp_say_drained", 64'(exp_say.size()), 64'd0);
        chk("exp_done_drained", 64'(exp_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
